// File: rtl/neuron_par_mac_if.sv
// Bus bundle for neuron_par_mac: input beats, weight/bias config broadcast and result.
// Optional: NEURON_PAR_SAT_FLAG_EN adds the sat_flag result qualifier.
interface neuron_par_mac_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16
);
    logic [LANES*DATA_W-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    w_valid;
    logic [LANES*DATA_W-1:0] w_data;
    logic                    b_valid;
    logic [DATA_W-1:0]       b_data;
    logic [7:0]              cfg_layer;
    logic [7:0]              cfg_neuron;
    logic [DATA_W-1:0]       out_data;
    logic                    out_valid;
    logic                    busy;
`ifdef NEURON_PAR_SAT_FLAG_EN
    logic                    sat_flag;
`endif

    modport master (
        output in_data, in_valid, w_valid, w_data, b_valid, b_data, cfg_layer, cfg_neuron,
        input  in_ready, out_data, out_valid, busy
`ifdef NEURON_PAR_SAT_FLAG_EN
        , input sat_flag
`endif
    );

    modport slave (
        input  in_data, in_valid, w_valid, w_data, b_valid, b_data, cfg_layer, cfg_neuron,
        output in_ready, out_data, out_valid, busy
`ifdef NEURON_PAR_SAT_FLAG_EN
        , output sat_flag
`endif
    );
endinterface

// File: rtl/neuron_par_mac.sv
// neuron_par_mac: LANES-wide fully-connected neuron with loadable weights/bias,
// saturating accumulation and ReLU with output clamp.
// Optional: define NEURON_PAR_SAT_FLAG_EN to add the sat_flag output.
module neuron_par_mac #(
    parameter int LAYER_ID   = 1,
    parameter int NEURON_ID  = 0,
    parameter int NUM_WEIGHT = 784,
    parameter int LANES      = 4,
    parameter int DATA_W     = 16,
    parameter int INT_W      = 4
) (
    input logic             clk,
    input logic             rst,
    neuron_par_mac_if.slave bus
);
    localparam int FRAC_W = DATA_W - INT_W;
    localparam int DEPTH  = NUM_WEIGHT / LANES;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW     = 2 * DATA_W;
    localparam int TW     = PW + $clog2(LANES) + 1;
    localparam int VW     = LANES * DATA_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACC   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_BIAS  = 3'd3;
    localparam logic [2:0] S_ACT   = 3'd4;

    localparam logic signed [PW-1:0] P_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] P_MIN = {1'b1, {(PW-1){1'b0}}};

    function automatic logic signed [PW-1:0] sx(input logic [DATA_W-1:0] v);
        return {{(PW-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // Clamp the full-growth lane sum back into the product width.
    function automatic logic signed [PW-1:0] sat_tree(input logic [TW-1:0] v);
        logic [TW-PW:0] top;
        top = v[TW-1:PW-1];
        if ((&top) || !(|top)) return v[PW-1:0];
        return v[TW-1] ? P_MIN : P_MAX;
    endfunction

    // Clamp a one-bit-grown sum of two product-width operands.
    function automatic logic signed [PW-1:0] sat_add(input logic [PW:0] s);
        if (s[PW] != s[PW-1]) return s[PW] ? P_MIN : P_MAX;
        return s[PW-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] relu(input logic signed [PW-1:0] s);
        logic signed [PW-1:0] r;
        r = s >>> FRAC_W;
        if (s[PW-1]) return '0;
        if (|r[PW-1:DATA_W-1]) return {1'b0, {(DATA_W-1){1'b1}}};
        return r[DATA_W-1:0];
    endfunction

`ifdef NEURON_PAR_SAT_FLAG_EN
    function automatic logic tree_ovf(input logic [TW-1:0] v);
        logic [TW-PW:0] top;
        top = v[TW-1:PW-1];
        return !((&top) || !(|top));
    endfunction

    function automatic logic relu_ovf(input logic signed [PW-1:0] s);
        logic signed [PW-1:0] r;
        r = s >>> FRAC_W;
        return !s[PW-1] && (|r[PW-1:DATA_W-1]);
    endfunction
`endif

    logic [2:0]            state;
    logic [AW-1:0]         cnt;
    logic [AW-1:0]         wptr;
    logic                  accept;
    logic                  busy_w;
    logic                  cfg_hit;
    logic [VW-1:0]         mem [DEPTH];
    logic [VW-1:0]         x_p0;
    logic [VW-1:0]         w_p0;
    logic                  vld_p0;
    logic signed [PW-1:0]  prod_p1 [LANES];
    logic                  vld_p1;
    logic signed [TW-1:0]  tree_full;
    logic signed [PW-1:0]  tree_p2;
    logic                  vld_p2;
    logic signed [PW-1:0]  acc;
    logic signed [PW-1:0]  bias_al;
    logic signed [PW-1:0]  sum_p3;
    logic [PW:0]           acc_sum;
    logic [PW:0]           bias_sum;
    logic [DATA_W-1:0]     bias_r;
    logic [DATA_W-1:0]     out_data_r;
    logic                  out_valid_r;

    assign bus.in_ready  = (state == S_IDLE) || (state == S_ACC);
    assign accept        = bus.in_valid && bus.in_ready;
    assign busy_w        = (state != S_IDLE) || out_valid_r;
    assign bus.busy      = busy_w;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign cfg_hit       = (bus.cfg_layer == 8'(LAYER_ID)) && (bus.cfg_neuron == 8'(NEURON_ID)) && !busy_w;
    assign bias_al       = sx(bias_r) <<< FRAC_W;
    assign acc_sum       = {acc[PW-1], acc} + {tree_p2[PW-1], tree_p2};
    assign bias_sum      = {acc[PW-1], acc} + {bias_al[PW-1], bias_al};

    // Lane adder tree at full growth; saturation happens on the way into tree_p2.
    always_comb begin
        tree_full = '0;
        for (int i = 0; i < LANES; i++)
            tree_full = tree_full + {{(TW-PW){prod_p1[i][PW-1]}}, prod_p1[i]};
    end

    // Sequencer, beat counter, config claim and pipeline valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            wptr   <= '0;
            bias_r <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (bus.w_valid && cfg_hit)
                wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + 1'b1;
            if (bus.b_valid && cfg_hit)
                bias_r <= bus.b_data;
            case (state)
                S_IDLE, S_ACC: begin
                    if (accept) begin
                        if (cnt == AW'(DEPTH-1)) begin
                            cnt   <= '0;
                            state <= S_DRAIN;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_ACC;
                        end
                    end
                end
                // The last beat has reached the accumulator once nothing is behind it.
                S_DRAIN: if (vld_p2 && !vld_p1 && !vld_p0) state <= S_BIAS;
                S_BIAS:  state <= S_ACT;
                S_ACT:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Weight memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.w_valid && cfg_hit) mem[wptr] <= bus.w_data;
    end

    // Datapath registers (no reset: qualified by the valids and the FSM).
    always_ff @(posedge clk) begin
        // stage p0: input beat and its weight word (synchronous read)
        if (accept) begin
            x_p0 <= bus.in_data;
            w_p0 <= mem[cnt];
        end
        // stage p1: per-lane products
        for (int i = 0; i < LANES; i++)
            prod_p1[i] <= sx(x_p0[i*DATA_W +: DATA_W]) * sx(w_p0[i*DATA_W +: DATA_W]);
        // stage p2: saturated lane sum
        tree_p2 <= sat_tree(tree_full);
        // stage p3: bias-aligned final sum
        if (state == S_BIAS) sum_p3 <= sat_add(bias_sum);
    end

    // Saturating accumulator, cleared as the result is presented.
    always_ff @(posedge clk) begin
        if (rst || state == S_ACT) acc <= '0;
        else if (vld_p2)           acc <= sat_add(acc_sum);
    end

    // Activation output register and result pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            out_valid_r <= (state == S_ACT);
            if (state == S_ACT) out_data_r <= relu(sum_p3);
        end
    end

`ifdef NEURON_PAR_SAT_FLAG_EN
    logic sat_trk;
    logic sat_r;

    // Sticky saturation record per inference, published with the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_trk <= 1'b0;
            sat_r   <= 1'b0;
        end else begin
            if (state == S_IDLE && accept)
                sat_trk <= 1'b0;
            else if ((vld_p1 && tree_ovf(tree_full)) || (vld_p2 && (acc_sum[PW] != acc_sum[PW-1])) ||
                     (state == S_BIAS && (bias_sum[PW] != bias_sum[PW-1])))
                sat_trk <= 1'b1;
            if (state == S_ACT) sat_r <= sat_trk || relu_ovf(sum_p3);
        end
    end

    assign bus.sat_flag = sat_r && out_valid_r;
`endif
endmodule

// File: tb/tb_neuron_par_mac.sv
// Directed bench for neuron_par_mac (LANES=2, NUM_WEIGHT=4, DATA_W=16, INT_W=4).
module tb_neuron_par_mac;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic seen;

    always #5 clk = ~clk;

    neuron_par_mac_if #(.LANES(2), .DATA_W(16)) bus ();

    neuron_par_mac #(
        .LAYER_ID(1), .NEURON_ID(0), .NUM_WEIGHT(4), .LANES(2), .DATA_W(16), .INT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_w(input logic [7:0] l, input logic [7:0] n, input logic [31:0] d);
        bus.cfg_layer  = l;
        bus.cfg_neuron = n;
        bus.w_data     = d;
        bus.w_valid    = 1'b1;
        step();
        bus.w_valid    = 1'b0;
    endtask

    task automatic wr_b(input logic [7:0] l, input logic [7:0] n, input logic [15:0] d);
        bus.cfg_layer  = l;
        bus.cfg_neuron = n;
        bus.b_data     = d;
        bus.b_valid    = 1'b1;
        step();
        bus.b_valid    = 1'b0;
    endtask

    // Two beats of {xv,xv} with gap idle cycles between; checks result, latency and handshake.
    task automatic run(input string tag, input logic [15:0] xv, input int gap, input bit busy_wr,
                       input logic [15:0] expv, input logic exp_sat);
        int   lat;
        logic rdy_bad;
        bus.in_data = {xv, xv};
        chk({tag, " ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (gap) step();
        chk({tag, " ready_acc"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk({tag, " busy_run"}, 32'(bus.busy), 32'd1);
        if (busy_wr) begin
            bus.cfg_layer  = 8'd1;
            bus.cfg_neuron = 8'd0;
            bus.w_data     = {16'h7FFF, 16'h7FFF};
            bus.w_valid    = 1'b1;
        end
        lat = 1;
        rdy_bad = 1'b0;
        while (!bus.out_valid && lat < 12) begin
            if (bus.in_ready) rdy_bad = 1'b1;
            step();
            bus.w_valid = 1'b0;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd6);
        chk({tag, " ready_low"}, 32'(rdy_bad), 32'd0);
        chk({tag, " out_data"}, 32'(bus.out_data), 32'(expv));
        chk({tag, " ready_at_out"}, 32'(bus.in_ready), 32'd1);
        chk({tag, " busy_at_out"}, 32'(bus.busy), 32'd1);
`ifdef NEURON_PAR_SAT_FLAG_EN
        chk({tag, " sat_flag"}, 32'(bus.sat_flag), 32'(exp_sat));
`else
        if (exp_sat === 1'bx) $display("note: unexpected sat expectation");
`endif
        step();
        chk({tag, " pulse_end"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " out_hold"}, 32'(bus.out_data), 32'(expv));
        chk({tag, " busy_end"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.w_valid    = 1'b0;
        bus.w_data     = '0;
        bus.b_valid    = 1'b0;
        bus.b_data     = '0;
        bus.cfg_layer  = '0;
        bus.cfg_neuron = '0;
        repeat (3) step();
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_data", 32'(bus.out_data), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        step();

        // 1.0 weights, 0.5 inputs, zero bias: 4 * 0.5 = 2.0
        wr_w(8'd1, 8'd0, {16'h1000, 16'h1000});
        wr_w(8'd1, 8'd0, {16'h1000, 16'h1000});
        wr_b(8'd1, 8'd0, 16'h0000);
        run("base", 16'h0800, 0, 1'b0, 16'h2000, 1'b0);

        // bias -3.0 drives the sum to -1.0, ReLU clips to zero
        wr_b(8'd1, 8'd0, 16'hD000);
        run("neg", 16'h0800, 0, 1'b0, 16'h0000, 1'b0);

        // mismatched IDs are ignored; matched write while busy is ignored
        wr_b(8'd1, 8'd0, 16'h0000);
        wr_w(8'd1, 8'd1, {16'h7FFF, 16'h7FFF});
        wr_w(8'd2, 8'd0, {16'h7FFF, 16'h7FFF});
        wr_b(8'd1, 8'd1, 16'h4000);
        run("id_miss", 16'h0800, 0, 1'b1, 16'h2000, 1'b0);

        // valid gaps 1,0,0,1 give the same answer
        run("gaps", 16'h0800, 2, 1'b0, 16'h2000, 1'b0);

        // reset mid-inference with a nonzero bias loaded
        wr_b(8'd1, 8'd0, 16'hD000);
        bus.in_data  = {16'h0800, 16'h0800};
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("mid busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort out_data", 32'(bus.out_data), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            if (bus.out_valid) seen = 1'b1;
            step();
        end
        chk("abort no out_valid", 32'(seen), 32'd0);
        run("post_rst", 16'h0800, 0, 1'b0, 16'h2000, 1'b0);

        // max weights and inputs overflow the accumulator
        wr_w(8'd1, 8'd0, {16'h7FFF, 16'h7FFF});
        wr_w(8'd1, 8'd0, {16'h7FFF, 16'h7FFF});
        run("sat", 16'h7FFF, 0, 1'b0, 16'h7FFF, 1'b1);

        // five writes wrap the pointer: word0 = 2.0, word1 = 1.0 -> 2.0 + 1.0 = 3.0
        wr_w(8'd1, 8'd0, {16'h7FFF, 16'h7FFF});
        wr_w(8'd1, 8'd0, {16'h7FFF, 16'h7FFF});
        wr_w(8'd1, 8'd0, {16'h7FFF, 16'h7FFF});
        wr_w(8'd1, 8'd0, {16'h1000, 16'h1000});
        wr_w(8'd1, 8'd0, {16'h2000, 16'h2000});
        run("wrap", 16'h0800, 0, 1'b0, 16'h3000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
